// File: rtl/sr_ff.sv
// Multi-lane clocked SR flip-flop. The S=R=1 resolution is set by INVALID_MODE.
// Optional per-lane sticky error output is enabled by defining SR_FF_STICKY_ERR_EN.
module sr_ff #(
  parameter int                 WIDTH        = 1,
  parameter int                 INVALID_MODE = 0,
  parameter logic [WIDTH-1:0]   RESET_VAL    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] invalid
`ifdef SR_FF_STICKY_ERR_EN
  ,
  output logic [WIDTH-1:0] err_sticky
`endif
);

  logic [WIDTH-1:0] both;
  logic [WIDTH-1:0] q_resolved;
  logic [WIDTH-1:0] q_next;

  assign both = s & r;

  // Value taken by lanes that see s=r=1. Unknown modes fall back to hold.
  generate
    if (INVALID_MODE == 1) begin : g_force_set
      assign q_resolved = '1;
    end else if (INVALID_MODE == 2) begin : g_force_reset
      assign q_resolved = '0;
    end else if (INVALID_MODE == 3) begin : g_toggle
      assign q_resolved = ~q;
    end else begin : g_hold
      assign q_resolved = q;
    end
  endgenerate

  always_comb begin
    q_next = (s & ~r) | (~s & ~r & q) | (both & q_resolved);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= RESET_VAL;
      invalid <= '0;
    end else begin
      q       <= q_next;
      invalid <= both;
    end
  end

  assign q_bar = ~q;

`ifdef SR_FF_STICKY_ERR_EN
  // The error flag survives later valid inputs. Only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= '0;
    end else begin
      err_sticky <= err_sticky | both;
    end
  end
`endif

endmodule

// File: tb/tb_sr_ff.sv
// Directed bench for sr_ff: one-bit lanes in every INVALID_MODE (plus an illegal mode),
// and a four-lane instance with a non-zero RESET_VAL.
module tb_sr_ff;

  logic       clk = 1'b0;
  logic       rst;
  logic       s1, r1;
  logic [3:0] s4, r4;

  logic q_m0, qb_m0, inv_m0;
  logic q_m1, qb_m1, inv_m1;
  logic q_m2, qb_m2, inv_m2;
  logic q_m3, qb_m3, inv_m3;
  logic q_m5, qb_m5, inv_m5;
  logic [3:0] q_w, qb_w, inv_w;
`ifdef SR_FF_STICKY_ERR_EN
  logic err_m0, err_m1, err_m2, err_m3, err_m5;
  logic [3:0] err_w;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sr_ff #(.WIDTH(1), .INVALID_MODE(0)) u_m0 (.clk(clk), .rst(rst), .s(s1), .r(r1),
    .q(q_m0), .q_bar(qb_m0), .invalid(inv_m0)
`ifdef SR_FF_STICKY_ERR_EN
    , .err_sticky(err_m0)
`endif
  );
  sr_ff #(.WIDTH(1), .INVALID_MODE(1)) u_m1 (.clk(clk), .rst(rst), .s(s1), .r(r1),
    .q(q_m1), .q_bar(qb_m1), .invalid(inv_m1)
`ifdef SR_FF_STICKY_ERR_EN
    , .err_sticky(err_m1)
`endif
  );
  sr_ff #(.WIDTH(1), .INVALID_MODE(2)) u_m2 (.clk(clk), .rst(rst), .s(s1), .r(r1),
    .q(q_m2), .q_bar(qb_m2), .invalid(inv_m2)
`ifdef SR_FF_STICKY_ERR_EN
    , .err_sticky(err_m2)
`endif
  );
  sr_ff #(.WIDTH(1), .INVALID_MODE(3)) u_m3 (.clk(clk), .rst(rst), .s(s1), .r(r1),
    .q(q_m3), .q_bar(qb_m3), .invalid(inv_m3)
`ifdef SR_FF_STICKY_ERR_EN
    , .err_sticky(err_m3)
`endif
  );
  sr_ff #(.WIDTH(1), .INVALID_MODE(5)) u_m5 (.clk(clk), .rst(rst), .s(s1), .r(r1),
    .q(q_m5), .q_bar(qb_m5), .invalid(inv_m5)
`ifdef SR_FF_STICKY_ERR_EN
    , .err_sticky(err_m5)
`endif
  );
  sr_ff #(.WIDTH(4), .INVALID_MODE(0), .RESET_VAL(4'b1010)) u_w (.clk(clk), .rst(rst),
    .s(s4), .r(r4), .q(q_w), .q_bar(qb_w), .invalid(inv_w)
`ifdef SR_FF_STICKY_ERR_EN
    , .err_sticky(err_w)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst_v, input logic s_v, input logic r_v,
                       input logic [3:0] s4_v, input logic [3:0] r4_v);
    rst = rst_v;
    s1  = s_v;
    r1  = r_v;
    s4  = s4_v;
    r4  = r4_v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // q of the mode 0/1/2/3/illegal single-lane instances
  task automatic chk_modes(input string tag, input logic e0, input logic e1, input logic e2,
                           input logic e3, input logic e5);
    chk({tag, "_m0"}, q_m0, e0);
    chk({tag, "_m1"}, q_m1, e1);
    chk({tag, "_m2"}, q_m2, e2);
    chk({tag, "_m3"}, q_m3, e3);
    chk({tag, "_m5"}, q_m5, e5);
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111);
    // A: reset wins over s=r=1
    tick();
    chk_modes("rst_q", 0, 0, 0, 0, 0);
    chk("rst_qbar", qb_m0, 1'b1);
    chk("rst_inv", inv_m0, 1'b0);
    chk("rst_w_q", q_w, 4'b1010);
    chk("rst_w_inv", inv_w, 4'b0000);
`ifdef SR_FF_STICKY_ERR_EN
    chk("rst_err", err_m0, 1'b0);
`endif

    // B: release reset, hold; wide lanes see s=0101 r=0010
    drive(1'b0, 1'b0, 1'b0, 4'b0101, 4'b0010);
    tick();
    chk_modes("rel_hold", 0, 0, 0, 0, 0);
    chk("w_mixed_q", q_w, 4'b1101);
    chk("w_mixed_qbar", qb_w, 4'b0010);

    // C: set
    drive(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    tick();
    chk_modes("set_q", 1, 1, 1, 1, 1);
    chk("set_qbar", qb_m0, 1'b0);
    // inputs changing between edges must not affect q
    s1 = 1'b0; r1 = 1'b1;
    #2;
    chk("between_edges", q_m0, 1'b1);

    // D, E: hold for two edges
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    tick();
    chk("hold1_q", q_m0, 1'b1);
    tick();
    chk("hold2_q", q_m0, 1'b1);
    chk("hold_w_q", q_w, 4'b1101);

    // F: reset input
    drive(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    tick();
    chk_modes("clr_q", 0, 0, 0, 0, 0);
    chk("clr_qbar", qb_m0, 1'b1);

    // G: hold at 0
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    tick();
    chk("hold0_q", q_m0, 1'b0);
    chk("hold0_inv", inv_m0, 1'b0);
`ifdef SR_FF_STICKY_ERR_EN
    chk("pre_err", err_m0, 1'b0);
`endif

    // H, I, J: s=r=1 from q=0; toggle mode walks 1,0,1
    drive(1'b0, 1'b1, 1'b1, 4'b0011, 4'b0001);
    tick();
    chk_modes("inv1_q", 0, 1, 0, 1, 0);
    chk("inv1_flag", inv_m0, 1'b1);
    chk("inv1_flag_m3", inv_m3, 1'b1);
    chk("w_inv_q", q_w, 4'b1111);
    chk("w_inv_flag", inv_w, 4'b0001);
`ifdef SR_FF_STICKY_ERR_EN
    chk("inv1_err", err_m0, 1'b1);
    chk("w_err", err_w, 4'b0001);
`endif
    drive(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
    tick();
    chk_modes("inv2_q", 0, 1, 0, 0, 0);
    chk("w_inv_clr", inv_w, 4'b0000);
    tick();
    chk_modes("inv3_q", 0, 1, 0, 1, 0);

    // K: set, invalid flag drops
    drive(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    tick();
    chk_modes("set2_q", 1, 1, 1, 1, 1);
    chk("set2_inv", inv_m0, 1'b0);
`ifdef SR_FF_STICKY_ERR_EN
    chk("set2_err", err_m0, 1'b1);
`endif

    // L, M: s=r=1 from q=1 for two edges
    drive(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
    tick();
    chk_modes("inv4_q", 1, 1, 0, 0, 1);
    chk("inv4_flag", inv_m2, 1'b1);
    tick();
    chk_modes("inv5_q", 1, 1, 0, 1, 1);
    chk("inv5_flag", inv_m0, 1'b1);

    // N: valid input clears invalid but not sticky error
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    tick();
    chk_modes("post_q", 1, 1, 0, 1, 1);
    chk("post_inv", inv_m0, 1'b0);
`ifdef SR_FF_STICKY_ERR_EN
    chk("post_err", err_m0, 1'b1);
    chk("post_w_err", err_w, 4'b0001);
`endif

    // O: mid-operation reset overrides held state and s=r=1
    drive(1'b1, 1'b1, 1'b1, 4'b1111, 4'b0000);
    tick();
    chk_modes("midrst_q", 0, 0, 0, 0, 0);
    chk("midrst_inv", inv_m0, 1'b0);
    chk("midrst_w_q", q_w, 4'b1010);
    chk("midrst_w_qbar", qb_w, 4'b0101);
`ifdef SR_FF_STICKY_ERR_EN
    chk("midrst_err", err_m0, 1'b0);
    chk("midrst_w_err", err_w, 4'b0000);
`endif

    // P: hold after release
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    tick();
    chk("final_q", q_m0, 1'b0);
    chk("final_w_q", q_w, 4'b1010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
